cart_hdr_reader: RTL and testbench

Boot-time cartridge header reader that initiates ROM bus reads toward the active mapper, the bus-master side of the cartridge interface. On `start` it reads the 48-byte logo (0x0104–0x0133) twice, then the header block 0x0134–0x014D. It checks the logo against a reference sum, verifies the header checksum and extracts the CGB flag. The access pattern of two logo passes, each byte bracketed by an A15 low→high edge, is the one mappers rely on to detect header-read phases.

---
 rtl/cart_hdr_reader_pkg.sv | 26 ++
 rtl/cart_hdr_accum.sv | 73 +++++++
 rtl/cart_hdr_reader.sv | 132 +++++++++++++
 tb/tb_cart_hdr_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cart_hdr_reader_pkg.sv
// rtl/cart_hdr_reader_pkg.sv - header addresses and FSM/phase encodings for the cartridge header reader
package cart_hdr_reader_pkg;

    localparam int ADDR_W = 15;

    localparam logic [ADDR_W-1:0] HDR_LOGO_FIRST = 15'h0104;
    localparam logic [ADDR_W-1:0] HDR_LOGO_LAST  = 15'h0133;
    localparam logic [ADDR_W-1:0] HDR_HDR_FIRST  = 15'h0134;
    localparam logic [ADDR_W-1:0] HDR_CGB_FLAG   = 15'h0143;
    localparam logic [ADDR_W-1:0] HDR_CHK_LAST   = 15'h014C;
    localparam logic [ADDR_W-1:0] HDR_CHK_BYTE   = 15'h014D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_LOGO1 = 2'd0,
        PH_LOGO2 = 2'd1,
        PH_HDR   = 2'd2
    } phase_t;

endpackage

// File: rtl/cart_hdr_accum.sv
// rtl/cart_hdr_accum.sv - logo sums, header checksum and CGB flag accumulated per sampled byte
module cart_hdr_accum
    import cart_hdr_reader_pkg::*;
#(
    parameter logic [15:0] LOGO_SUM = 16'h1546
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              strobe_i,
    input  phase_t            phase_i,
    input  logic [ADDR_W-1:0] ptr_i,
    input  logic [7:0]        byte_i,
    output logic              logo_match_o,
    output logic              chk_match_o,
    output logic              is_cgb_o
);

    logic [15:0] sum1_q, sum1_d;
    logic [15:0] sum2_q, sum2_d;
    logic [7:0]  chk_q,  chk_d;
    logic        is_cgb_q, is_cgb_d;

    // Fold the byte sampled in DATA into whichever accumulator the current phase owns
    always_comb begin
        sum1_d   = sum1_q;
        sum2_d   = sum2_q;
        chk_d    = chk_q;
        is_cgb_d = is_cgb_q;
        if (clear_i) begin
            sum1_d   = 16'd0;
            sum2_d   = 16'd0;
            chk_d    = 8'd0;
            is_cgb_d = 1'b0;
        end else if (strobe_i) begin
            case (phase_i)
                PH_LOGO1: sum1_d = sum1_q + {8'd0, byte_i};
                PH_LOGO2: sum2_d = sum2_q + {8'd0, byte_i};
                PH_HDR: begin
                    // 0x014D is the stored checksum itself, so it is compared, not folded in
                    if (ptr_i != HDR_CHK_BYTE) begin
                        chk_d = chk_q - byte_i - 8'd1;
                    end
                    if (ptr_i == HDR_CGB_FLAG) begin
                        is_cgb_d = byte_i[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum1_q   <= 16'd0;
            sum2_q   <= 16'd0;
            chk_q    <= 8'd0;
            is_cgb_q <= 1'b0;
        end else begin
            sum1_q   <= sum1_d;
            sum2_q   <= sum2_d;
            chk_q    <= chk_d;
            is_cgb_q <= is_cgb_d;
        end
    end

    assign logo_match_o = (sum1_q == LOGO_SUM) && (sum2_q == LOGO_SUM);
    // Valid only while byte_i carries the 0x014D byte; the top latches it at that moment
    assign chk_match_o  = (chk_q == byte_i);
    assign is_cgb_o     = is_cgb_q;

endmodule

// File: rtl/cart_hdr_reader.sv
// rtl/cart_hdr_reader.sv - boot-time cartridge header scan: two logo passes then the header block
module cart_hdr_reader
    import cart_hdr_reader_pkg::*;
#(
    parameter logic [15:0] LOGO_SUM = 16'h1546
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_cpu,
    input  logic              start,
    input  logic [7:0]        cart_do,
    output logic [ADDR_W-1:0] cart_addr,
    output logic              cart_a15,
    output logic              cart_rd,
    output logic              cart_wr,
    output logic              nCS,
    output logic              busy,
    output logic              done,
    output logic              logo_ok,
    output logic              hdr_chk_ok,
    output logic              is_cgb
);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              logo_ok_q, logo_ok_d;
    logic              hdr_ok_q, hdr_ok_d;
    logic              clear;
    logic              strobe;
    logic              logo_match;
    logic              chk_match;

    // Sequencer: every read is one ADDR cycle (A15 low) and one DATA cycle (A15 high)
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ptr_d     = ptr_q;
        logo_ok_d = logo_ok_q;
        hdr_ok_d  = hdr_ok_q;
        clear     = 1'b0;
        strobe    = 1'b0;
        if (ce_cpu) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_ADDR;
                        phase_d   = PH_LOGO1;
                        ptr_d     = HDR_LOGO_FIRST;
                        logo_ok_d = 1'b0;
                        hdr_ok_d  = 1'b0;
                        clear     = 1'b1;
                    end
                end
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: begin
                    strobe  = 1'b1;
                    state_d = ST_ADDR;
                    ptr_d   = ptr_q + 15'd1;
                    case (phase_q)
                        PH_LOGO1: begin
                            if (ptr_q == HDR_LOGO_LAST) begin
                                phase_d = PH_LOGO2;
                                ptr_d   = HDR_LOGO_FIRST;
                            end
                        end
                        PH_LOGO2: begin
                            if (ptr_q == HDR_LOGO_LAST) begin
                                phase_d = PH_HDR;
                                ptr_d   = HDR_HDR_FIRST;
                            end
                        end
                        default: begin
                            // Address stays on 0x014D in DONE rather than walking past it
                            if (ptr_q == HDR_CHK_BYTE) begin
                                state_d   = ST_DONE;
                                ptr_d     = ptr_q;
                                logo_ok_d = logo_match;
                                hdr_ok_d  = chk_match;
                            end
                        end
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer and result registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_LOGO1;
            ptr_q     <= '0;
            logo_ok_q <= 1'b0;
            hdr_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ptr_q     <= ptr_d;
            logo_ok_q <= logo_ok_d;
            hdr_ok_q  <= hdr_ok_d;
        end
    end

    cart_hdr_accum #(
        .LOGO_SUM(LOGO_SUM)
    ) u_accum (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .clear_i     (clear),
        .strobe_i    (strobe),
        .phase_i     (phase_q),
        .ptr_i       (ptr_q),
        .byte_i      (cart_do),
        .logo_match_o(logo_match),
        .chk_match_o (chk_match),
        .is_cgb_o    (is_cgb)
    );

    // Bus pins decode straight from state so they hold whenever ce_cpu is low
    assign cart_addr  = ptr_q;
    assign cart_a15   = (state_q != ST_ADDR);
    assign cart_rd    = (state_q == ST_ADDR);
    assign cart_wr    = 1'b0;
    assign nCS        = 1'b1;
    assign busy       = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign done       = (state_q == ST_DONE);
    assign logo_ok    = logo_ok_q;
    assign hdr_chk_ok = hdr_ok_q;

endmodule

// File: tb/tb_cart_hdr_reader.sv
// tb/tb_cart_hdr_reader.sv - directed scans against a ROM image with a timeline model of the results
module tb_cart_hdr_reader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_cpu  = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  cart_do;
    logic [14:0] cart_addr;
    logic        cart_a15, cart_rd, cart_wr, nCS;
    logic        busy, done, logo_ok, hdr_chk_ok, is_cgb;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] LOGO [48] = '{
        8'hCE, 8'hED, 8'h66, 8'h66, 8'hCC, 8'h0D, 8'h00, 8'h0B, 8'h03, 8'h73, 8'h00, 8'h83,
        8'h00, 8'h0C, 8'h00, 8'h0D, 8'h00, 8'h08, 8'h11, 8'h1F, 8'h88, 8'h89, 8'h00, 8'h0E,
        8'hDC, 8'hCC, 8'h6E, 8'hE6, 8'hDD, 8'hDD, 8'hD9, 8'h99, 8'hBB, 8'hBB, 8'h67, 8'h63,
        8'h6E, 8'h0E, 8'hEC, 8'hCC, 8'hDD, 8'hDC, 8'h99, 8'h9F, 8'hBB, 8'hB9, 8'h33, 8'h3E
    };

    logic [7:0] rom [0:511];
    logic       corrupt2 = 1'b0;
    int         addr_cnt = 0;
    int         pass_no  = 0;
    int         e1 = 0, e2 = 0, e3 = 0;
    logic       prev_a15 = 1'b1;
    int         ce_div   = 0;

    cart_hdr_reader dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_cpu    (ce_cpu),
        .start     (start),
        .cart_do   (cart_do),
        .cart_addr (cart_addr),
        .cart_a15  (cart_a15),
        .cart_rd   (cart_rd),
        .cart_wr   (cart_wr),
        .nCS       (nCS),
        .busy      (busy),
        .done      (done),
        .logo_ok   (logo_ok),
        .hdr_chk_ok(hdr_chk_ok),
        .is_cgb    (is_cgb)
    );

    always #5 clk_sys = ~clk_sys;

    // ce_cpu on every 4th clock
    always @(negedge clk_sys) begin
        ce_div = (ce_div + 1) % 4;
        ce_cpu = (ce_div == 0);
    end

    // ROM path; optional single-bit corruption of 0x0110 on the second logo pass only
    always_comb begin
        cart_do = 8'hFF;
        if (cart_addr < 15'd512) cart_do = rom[cart_addr[8:0]];
        if (corrupt2 && cart_addr == 15'h0110 && addr_cnt > 48) cart_do = cart_do ^ 8'h01;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_logo();
        logic [15:0] s1;
        logic [15:0] s2;
        s1 = 16'd0;
        for (int i = 0; i < 48; i++) s1 = s1 + {8'd0, rom[9'h104 + i]};
        s2 = s1;
        if (corrupt2) s2 = s2 - {8'd0, rom[9'h110]} + {8'd0, rom[9'h110] ^ 8'h01};
        return (s1 == 16'h1546) && (s2 == 16'h1546);
    endfunction

    function automatic logic exp_hdr();
        int s;
        int t;
        s = 0;
        for (int i = 0; i < 25; i++) s += int'(rom[9'h134 + i]);
        t = -(s + 25);
        return t[7:0] == rom[9'h14D];
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        if (k < 48) return 32'h0104 + k;
        if (k < 96) return 32'h0104 + k - 48;
        return 32'h0134 + k - 96;
    endfunction

    // Timeline model: a scan is 244 ce_cpu cycles after the sampled start, results from the ROM image
    int   m_cnt  = 0;
    logic m_busy = 1'b0, m_done = 1'b0, m_logo = 1'b0, m_hdr = 1'b0, m_cgb = 1'b0;
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_logo <= 1'b0; m_hdr <= 1'b0; m_cgb <= 1'b0; m_cnt <= 0;
        end else if (ce_cpu) begin
            if (m_busy) begin
                if (m_cnt == 243) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_logo <= exp_logo(); m_hdr <= exp_hdr(); m_cgb <= rom[9'h143][7];
                end
                m_cnt <= m_cnt + 1;
            end else if (start) begin
                m_busy <= 1'b1; m_done <= 1'b0; m_logo <= 1'b0; m_hdr <= 1'b0; m_cgb <= 1'b0; m_cnt <= 0;
            end
        end
    end

    // Per-cycle compare plus read-order and A15-edge bookkeeping
    always @(negedge clk_sys) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("logo_ok", logo_ok, m_logo);
        chk("hdr_chk_ok", hdr_chk_ok, m_hdr);
        chk("cart_wr", cart_wr, 0);
        chk("nCS", nCS, 1);
        chk("rd_vs_a15", cart_rd, !cart_a15);
        if (!busy) chk("is_cgb", is_cgb, m_cgb);
        if (prev_a15 && !cart_a15) begin
            addr_cnt++;
            chk("read_addr", cart_addr, exp_addr(addr_cnt - 1));
        end
        if (!prev_a15 && cart_a15) begin
            if (pass_no == 0) e1++;
            else if (pass_no == 1) e2++;
            else e3++;
            if (cart_addr == 15'h0133) pass_no++;
        end
        prev_a15 = cart_a15;
    end

    task automatic init_rom(input logic [7:0] cgb);
        for (int i = 0; i < 512; i++) rom[i] = 8'h00;
        for (int i = 0; i < 48; i++) rom[9'h104 + i] = LOGO[i];
        rom[9'h143] = cgb;
        // All-zero header apart from 0x0143: checksum = -(25 + cgb) mod 256
        rom[9'h14D] = (cgb == 8'h80) ? 8'h67 : 8'hE7;
    endtask

    task automatic pulse_start();
        addr_cnt = 0; pass_no = 0; e1 = 0; e2 = 0; e3 = 0;
        @(negedge clk_sys);
        start = 1'b1;
        do @(posedge clk_sys); while (!ce_cpu);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, cart_addr, 0);
        chk({tag, "_a15"}, cart_a15, 1);
        chk({tag, "_rd"}, cart_rd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_logo"}, logo_ok, 0);
        chk({tag, "_hdr"}, hdr_chk_ok, 0);
        chk({tag, "_cgb"}, is_cgb, 0);
    endtask

    // mode 0: plain; 1: start pulsed mid-scan; 2: start held across the final DATA cycle
    task automatic run_scan(input int mode, input logic x_logo, input logic x_hdr, input logic x_cgb);
        int n;
        n = 0;
        pulse_start();
        while (!done && n < 300) begin
            @(posedge clk_sys);
            if (ce_cpu) n++;
            #1;
            if (mode == 1) start = (n >= 100 && n < 104);
            if (mode == 2 && addr_cnt == 122) start = 1'b1;
        end
        start = 1'b0;
        chk("ce_to_done", n, 244);
        chk("done_lit", done, 1);
        chk("logo_lit", logo_ok, x_logo);
        chk("hdr_lit", hdr_chk_ok, x_hdr);
        chk("cgb_lit", is_cgb, x_cgb);
        chk("reads", addr_cnt, 122);
        chk("edges_logo1", e1, 48);
        chk("edges_logo2", e2, 48);
        chk("edges_hdr", e3, 26);
        repeat (10) @(negedge clk_sys);
        chk("done_hold", done, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int k;
        init_rom(8'h80);
        repeat (3) @(negedge clk_sys);
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);

        run_scan(0, 1'b1, 1'b1, 1'b1);

        init_rom(8'h00);
        run_scan(0, 1'b1, 1'b1, 1'b0);

        corrupt2 = 1'b1;
        run_scan(0, 1'b0, 1'b1, 1'b0);
        corrupt2 = 1'b0;

        init_rom(8'h00);
        rom[9'h14D] = rom[9'h14D] + 8'h01;
        run_scan(0, 1'b1, 1'b0, 1'b0);

        init_rom(8'h80);
        run_scan(2, 1'b1, 1'b1, 1'b1);

        pulse_start();
        k = 0;
        while (addr_cnt < 61 && k < 2000) begin
            @(posedge clk_sys);
            k++;
            #1;
        end
        chk("reach_read60", addr_cnt, 61);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("midreset");
        repeat (5) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        run_scan(1, 1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
